// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the push-button debouncer
package debounce_pkg;

  // Bit 1 of the encoding is the debounced level (ONE and WAIT0 are the "high" half).
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

  // 2^21 cycles is roughly 21 ms at 100 MHz.
  localparam int DB_N_DEFAULT = 21;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs, async active-low reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_fsmd.sv
// rtl/debounce_fsmd.sv - switch debouncer: synchronizer plus four-state FSMD with 2^N-cycle stability window
module debounce_fsmd
  import debounce_pkg::*;
#(
  parameter int N = DB_N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick,
  output logic db_fall_tick
);

  localparam logic [N-1:0] Q_FULL = '1;

  logic         sw_s;
  db_state_e    state, state_n;
  logic [N-1:0] q, q_n;
  logic         tick_n, fall_tick_n;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  // Every entry into a wait state reloads q; an aborted wait never resumes its count.
  always_comb begin
    state_n     = state;
    q_n         = q;
    tick_n      = 1'b0;
    fall_tick_n = 1'b0;
    unique case (state)
      ZERO: begin
        if (sw_s) begin
          state_n = WAIT1;
          q_n     = Q_FULL;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_n = ZERO;
        end else if (q == '0) begin
          state_n = ONE;
          tick_n  = 1'b1;
        end else begin
          q_n = q - N'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_n = WAIT0;
          q_n     = Q_FULL;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_n = ONE;
        end else if (q == '0) begin
          state_n     = ZERO;
          fall_tick_n = 1'b1;
        end else begin
          q_n = q - N'(1);
        end
      end
      default: begin
        state_n = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ZERO;
      q            <= '0;
      db_tick      <= 1'b0;
      db_fall_tick <= 1'b0;
    end else begin
      state        <= state_n;
      q            <= q_n;
      db_tick      <= tick_n;
      db_fall_tick <= fall_tick_n;
    end
  end

  // Straight from the state register, so the level cannot glitch.
  assign db_level = (state == ONE) || (state == WAIT0);

endmodule

// File: tb/tb_debounce_fsmd.sv
// tb/tb_debounce_fsmd.sv - directed and randomized checks of debounce_fsmd against a run-length model
module tb_debounce_fsmd;

  localparam int N   = 4;
  localparam int LAT = (1 << N) + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sw    = 1'b0;
  logic db_level, db_tick, db_fall_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  int fall_cnt = 0;
  int hi_cnt   = 0;

  // Model: the synchronized input must disagree with the level for 2^N+1 consecutive edges.
  logic m_s1, m_s2, m_level, m_tick, m_fall;
  int   m_run;

  debounce_fsmd #(
    .N(N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .db_level     (db_level),
    .db_tick      (db_tick),
    .db_fall_tick (db_fall_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
    m_tick = 1'b0; m_fall = 1'b0; m_run = 0;
  endtask

  task automatic step(input logic v);
    logic sws;
    @(negedge clk);
    sw = v;
    @(posedge clk);
    if (reset) begin
      sws  = m_s2;
      m_s2 = m_s1;
      m_s1 = sw;
      m_tick = 1'b0;
      m_fall = 1'b0;
      if (sws != m_level) begin
        m_run++;
        if (m_run == (1 << N) + 1) begin
          m_level = sws;
          m_tick  = sws;
          m_fall  = !sws;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    check("level", db_level, m_level);
    check("tick", db_tick, m_tick);
    check("fall_tick", db_fall_tick, m_fall);
    tick_cnt += int'(db_tick);
    fall_cnt += int'(db_fall_tick);
    hi_cnt   += int'(db_level);
  endtask

  task automatic hold_until_level(input logic v, input logic want, input int max, output int n);
    n = 0;
    while (db_level !== want && n < max) begin
      step(v);
      n++;
    end
  endtask

  // Asserted mid-cycle so the clear is seen to act without a clock edge.
  task automatic pulse_reset(input int cycles);
    #2 reset = 1'b0;
    #1 model_reset();
    check("rst_level", db_level, 1'b0);
    check("rst_tick", db_tick, 1'b0);
    check("rst_fall_tick", db_fall_tick, 1'b0);
    repeat (cycles) step(sw);
    #2 reset = 1'b1;
  endtask

  initial begin
    int n, n2, t0, f0, h0;

    sw = 1'b1;
    #2 reset = 1'b0;
    #1 model_reset();
    check("init_level", db_level, 1'b0);
    check("init_tick", db_tick, 1'b0);
    check("init_fall_tick", db_fall_tick, 1'b0);
    repeat (3) step(1'b1);
    #2 reset = 1'b1;
    t0 = tick_cnt;
    hold_until_level(1'b1, 1'b1, 100, n);
    check("rst_release_latency", n - 1, LAT);
    check("rst_release_ticks", tick_cnt - t0, 1);

    repeat (LAT + 2) step(1'b0);

    t0 = tick_cnt; f0 = fall_cnt;
    hold_until_level(1'b1, 1'b1, 100, n);
    check("press_latency", n - 1, LAT);
    repeat (40 - n) step(1'b1);
    hold_until_level(1'b0, 1'b0, 100, n2);
    check("release_latency", n2 - 1, LAT);
    check("level_high_cycles", 40 + n2 - n, 40);
    check("press_ticks", tick_cnt - t0, 1);
    check("press_fall_ticks", fall_cnt - f0, 1);

    t0 = tick_cnt; h0 = hi_cnt;
    repeat (16) step(1'b1);
    repeat (LAT + 4) step(1'b0);
    check("glitch16_ticks", tick_cnt - t0, 0);
    check("glitch16_high", hi_cnt - h0, 0);

    t0 = tick_cnt; f0 = fall_cnt; h0 = hi_cnt;
    repeat (17) step(1'b1);
    repeat (40) step(1'b0);
    check("pulse17_ticks", tick_cnt - t0, 1);
    check("pulse17_falls", fall_cnt - f0, 1);
    check("pulse17_high", hi_cnt - h0, (1 << N) + 1);

    t0 = tick_cnt;
    for (int seg = 0; seg < 10; seg++) repeat (3) step(seg % 2 == 0);
    check("bounce_ticks_during", tick_cnt - t0, 0);
    hold_until_level(1'b1, 1'b1, 100, n);
    check("bounce_latency", n - 1, LAT);
    check("bounce_ticks", tick_cnt - t0, 1);

    repeat (4) step(1'b1);
    t0 = tick_cnt; f0 = fall_cnt;
    repeat (10) step(1'b0);
    repeat (2) step(1'b1);
    check("rel_bounce_hold", db_level, 1'b1);
    hold_until_level(1'b0, 1'b0, 100, n);
    check("rel_bounce_latency", n - 1, LAT);
    check("rel_bounce_falls", fall_cnt - f0, 1);
    check("rel_bounce_ticks", tick_cnt - t0, 0);

    repeat (4) step(1'b0);
    repeat (11) step(1'b1);
    pulse_reset(2);
    t0 = tick_cnt;
    hold_until_level(1'b1, 1'b1, 100, n);
    check("wait1_reset_latency", n - 1, LAT);
    check("wait1_reset_ticks", tick_cnt - t0, 1);

    for (int r = 0; r < 150; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 40));
      if ($urandom_range(0, 19) == 0) pulse_reset(int'($urandom_range(1, 3)));
      for (int i = 0; i < len; i++) step(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
